// File: rtl/multiplexor_display_7s.sv
`default_nettype none
// ============================================================================
// Module   : multiplexor_display_7s
// Brief    : Scans X, Y, sign and result codes onto a 4-digit common-anode
//            7-segment bank with per-slot blanking and frame snapshots.
// Revision : 1.0 - initial release
// ============================================================================
module multiplexor_display_7s #(
    parameter int PRESCALER      = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Enable,
    input  logic [6:0] X_Display,
    input  logic [6:0] Y_Display,
    input  logic [6:0] Resultado_Display,
    input  logic       CarrieNegSalida,
    output logic [6:0] Segmentos,
    output logic [3:0] Anodos,
    output logic       FinBarrido
);

    localparam int               c_cnt_w      = $clog2(PRESCALER);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(PRESCALER - 1);
    localparam logic [6:0]       c_seg_off    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]       c_an_off     = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
    localparam logic [6:0]       c_sign_minus = 7'b1000000;

    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_dig;
    logic [6:0]         r_sx;
    logic [6:0]         r_sy;
    logic [6:0]         r_sr;
    logic               r_sn;
    logic [6:0]         r_seg;
    logic [3:0]         r_an;
    logic               r_fin;

    logic               w_blank_phase;
    logic               w_slot_end;
    logic               w_frame_start;
    logic [6:0]         w_code;
    logic [3:0]         w_an_onehot;

    // With no blank time the compare would be constant, so drop it entirely.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign w_blank_phase = 1'b0;
        end else begin : g_blank
            localparam logic [c_cnt_w-1:0] c_blank = c_cnt_w'(BLANK_CYCLES);
            assign w_blank_phase = (r_cnt < c_blank);
        end
    endgenerate

    assign w_slot_end    = (r_cnt == c_cnt_last);
    assign w_frame_start = (r_cnt == '0) && (r_dig == 2'd0);
    assign w_an_onehot   = 4'b0001 << r_dig;

    always_comb begin
        w_code = r_sx;
        case (r_dig)
            2'd0:    w_code = r_sr;
            2'd1:    w_code = r_sn ? c_sign_minus : 7'h00;
            2'd2:    w_code = r_sy;
            default: w_code = r_sx;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_dig <= 2'd0;
        end else if (!Enable) begin
            r_cnt <= '0;
            r_dig <= 2'd0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_dig <= r_dig + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Snapshot is taken once per frame so a digit never changes mid-scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sx <= 7'h00;
            r_sy <= 7'h00;
            r_sr <= 7'h00;
            r_sn <= 1'b0;
        end else if (Enable && w_frame_start) begin
            r_sx <= X_Display;
            r_sy <= Y_Display;
            r_sr <= Resultado_Display;
            r_sn <= CarrieNegSalida;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= c_an_off;
            r_seg <= c_seg_off;
            r_fin <= 1'b0;
        end else if (!Enable) begin
            r_an  <= c_an_off;
            r_seg <= c_seg_off;
            r_fin <= 1'b0;
        end else begin
            if (w_blank_phase) begin
                r_an  <= c_an_off;
                r_seg <= c_seg_off;
            end else begin
                r_an  <= w_an_onehot ^ c_an_off;
                r_seg <= w_code ^ c_seg_off;
            end
            r_fin <= w_slot_end && (r_dig == 2'd3);
        end
    end

    assign Segmentos  = r_seg;
    assign Anodos     = r_an;
    assign FinBarrido = r_fin;

endmodule
`default_nettype wire

// File: tb/tb_multiplexor_display_7s.sv
`default_nettype none
// Testbench for multiplexor_display_7s: directed vector table, corner-case
// sequences and randomized traffic against a frame-position reference model.
module tb_multiplexor_display_7s;

    localparam int P_A = 8;
    localparam int B_A = 2;
    localparam int P_B = 2;
    localparam int B_B = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Enable;
    logic [6:0] X_Display, Y_Display, Resultado_Display;
    logic       CarrieNegSalida;
    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;
    logic       fin_a, fin_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    multiplexor_display_7s #(
        .PRESCALER(P_A), .BLANK_CYCLES(B_A), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .Enable(Enable),
        .X_Display(X_Display), .Y_Display(Y_Display),
        .Resultado_Display(Resultado_Display), .CarrieNegSalida(CarrieNegSalida),
        .Segmentos(seg_a), .Anodos(an_a), .FinBarrido(fin_a)
    );

    multiplexor_display_7s #(
        .PRESCALER(P_B), .BLANK_CYCLES(B_B), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .Enable(Enable),
        .X_Display(X_Display), .Y_Display(Y_Display),
        .Resultado_Display(Resultado_Display), .CarrieNegSalida(CarrieNegSalida),
        .Segmentos(seg_b), .Anodos(an_b), .FinBarrido(fin_b)
    );

    // Reference model: position within the 4*P-cycle frame plus snapshot.
    typedef struct packed {
        int         pos;
        logic [6:0] sx, sy, sr;
        logic       sn;
        logic [3:0] an;
        logic [6:0] seg;
        logic       fin;
    } model_t;

    model_t m_a, m_b;

    function automatic model_t model_reset();
        model_t o;
        o.pos = 0; o.sx = 7'h00; o.sy = 7'h00; o.sr = 7'h00; o.sn = 1'b0;
        o.an = 4'hF; o.seg = 7'h7F; o.fin = 1'b0;
        return o;
    endfunction

    function automatic model_t model_step(model_t m, int p, int b, logic en,
                                          logic [6:0] x, logic [6:0] y,
                                          logic [6:0] r, logic n);
        model_t o;
        int slot, off;
        logic [6:0] code;
        o = m;
        o.an = 4'hF; o.seg = 7'h7F; o.fin = 1'b0;
        if (!en) begin
            o.pos = 0;
            return o;
        end
        slot = m.pos / p;
        off  = m.pos % p;
        case (slot)
            0:       code = m.sr;
            1:       code = m.sn ? 7'h40 : 7'h00;
            2:       code = m.sy;
            default: code = m.sx;
        endcase
        if (off >= b) begin
            o.an  = ~(4'(1) << slot);
            o.seg = ~code;
        end
        o.fin = (m.pos == 4 * p - 1);
        if (m.pos == 0) begin
            o.sx = x; o.sy = y; o.sr = r; o.sn = n;
        end
        o.pos = (m.pos + 1) % (4 * p);
        return o;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock: advance the models and compare both DUTs after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_a = model_reset();
            m_b = model_reset();
        end else begin
            m_a = model_step(m_a, P_A, B_A, Enable, X_Display, Y_Display, Resultado_Display, CarrieNegSalida);
            m_b = model_step(m_b, P_B, B_B, Enable, X_Display, Y_Display, Resultado_Display, CarrieNegSalida);
        end
        #1;
        check("model_a", {an_a, seg_a, fin_a}, {m_a.an, m_a.seg, m_a.fin});
        check("model_b", {an_b, seg_b, fin_b}, {m_b.an, m_b.seg, m_b.fin});
    endtask

    task automatic resync();
        Enable = 1'b0;
        tick();
        Enable = 1'b1;
    endtask

    typedef struct packed {
        logic [6:0]      x, y, r;
        logic            n;
        logic [3:0][6:0] exp_seg;
    } vec_t;

    localparam logic [3:0] c_an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    vec_t vecs [3];

    initial begin
        vecs[0] = '{7'h4F, 7'h5B, 7'h06, 1'b1, {7'h30, 7'h24, 7'h3F, 7'h79}};
        vecs[1] = '{7'h4F, 7'h5B, 7'h06, 1'b0, {7'h30, 7'h24, 7'h7F, 7'h79}};
        vecs[2] = '{7'h00, 7'h7F, 7'h3F, 1'b0, {7'h7F, 7'h00, 7'h7F, 7'h40}};

        rst_n = 1'b0; Enable = 1'b1;
        X_Display = 7'h4F; Y_Display = 7'h5B; Resultado_Display = 7'h06; CarrieNegSalida = 1'b1;
        m_a = model_reset(); m_b = model_reset();

        // Reset held with Enable high
        for (int i = 0; i < 5; i++) begin
            tick();
            check("reset_a", {an_a, seg_a, fin_a}, {4'hF, 7'h7F, 1'b0});
        end
        rst_n = 1'b1;

        // Table-driven full frames
        for (int v = 0; v < 3; v++) begin
            resync();
            X_Display = vecs[v].x; Y_Display = vecs[v].y;
            Resultado_Display = vecs[v].r; CarrieNegSalida = vecs[v].n;
            for (int k = 1; k <= 4 * P_A; k++) begin
                int dig, cnt;
                logic [11:0] e;
                tick();
                dig = (k - 1) / P_A;
                cnt = (k - 1) % P_A;
                e = (cnt < B_A) ? {4'hF, 7'h7F, 1'b0} : {c_an_exp[dig], vecs[v].exp_seg[dig], 1'b0};
                if (k == 4 * P_A) e[0] = 1'b1;
                check("vec_frame", {an_a, seg_a, fin_a}, e);
            end
        end

        // No tearing: X changes during the digit-2 slot
        resync();
        X_Display = 7'h4F; CarrieNegSalida = 1'b1;
        for (int k = 1; k <= 8 * P_A; k++) begin
            tick();
            if (k == 18) X_Display = 7'h66;
            if (k == 28) check("tear_same_frame", {5'd0, seg_a}, {5'd0, 7'h30});
            if (k == 60) check("tear_next_frame", {5'd0, seg_a}, {5'd0, 7'h19});
        end

        // Enable dropped during the digit-1 SHOW phase
        resync();
        for (int k = 1; k <= 12; k++) tick();
        check("en_before_drop", {8'd0, an_a}, {8'd0, 4'b1101});
        Enable = 1'b0;
        tick();
        check("en_drop_dark", {an_a, seg_a, fin_a}, {4'hF, 7'h7F, 1'b0});
        for (int k = 0; k < 30; k++) begin
            tick();
            check("en_low_no_fin", {11'd0, fin_a}, 12'd0);
        end
        Resultado_Display = 7'h5B;
        Enable = 1'b1;
        tick();
        check("en_restart_blank1", {8'd0, an_a}, {8'd0, 4'hF});
        tick();
        check("en_restart_blank2", {8'd0, an_a}, {8'd0, 4'hF});
        tick();
        check("en_restart_dig0", {an_a, seg_a}, {4'b1110, 7'h24, 1'b0} >> 1);

        // Enable falls in the same cycle as the frame end
        resync();
        for (int k = 1; k <= 4 * P_A - 1; k++) tick();
        Enable = 1'b0;
        tick();
        check("en_vs_frame_end", {11'd0, fin_a}, 12'd0);

        // Asynchronous reset mid-slot
        resync();
        for (int k = 1; k <= 13; k++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_a", {an_a, seg_a, fin_a}, {4'hF, 7'h7F, 1'b0});
        check("async_rst_b", {an_b, seg_b, fin_b}, {4'hF, 7'h7F, 1'b0});
        tick();
        rst_n = 1'b1;

        // PRESCALER=2, no blank: anode steps every 2 cycles, frame every 8
        resync();
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("p2_scan", {7'd0, an_b, fin_b},
                  {7'd0, c_an_exp[((k - 1) / P_B) % 4], (k % 8) == 0});
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            X_Display = 7'($urandom);
            Y_Display = 7'($urandom);
            Resultado_Display = 7'($urandom);
            CarrieNegSalida = 1'($urandom);
            Enable = ($urandom_range(0, 39) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multiplexor_display_7s.md
Name: multiplexor_display_7s

Overview:
- Downstream stage of the 4-bit subtractor with 7-segment outputs.
- Consumes the three per-digit segment codes (X, Y, result) plus the negative/borrow flag.
- Time-multiplexes them onto one 4-digit common-anode display bank (shared segment bus, one anode per digit) using a prescaled scan counter with anti-ghosting blank time.
- Latches a frame snapshot so the displayed digits never tear mid-scan.

Parameters:
- PRESCALER, 50000: clock cycles per digit slot; legal range 2 to 2^20.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; legal range 0 to PRESCALER-1.
- SEG_ACTIVE_LOW, 1: 1 means Segmentos is active-low on the pins; 0 means active-high.
- AN_ACTIVE_LOW, 1: 1 means Anodos is active-low; 0 means active-high.

Ports:
- clk, in, 1: single system clock; all state updates on the rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- Enable, in, 1: 1 = scan; 0 = display dark, scan held.
- X_Display, in, 7: segment code for operand X; active-high; bit0 = a ... bit6 = g.
- Y_Display, in, 7: segment code for operand Y; same encoding.
- Resultado_Display, in, 7: segment code for the result; same encoding.
- CarrieNegSalida, in, 1: 1 = result negative; drives the sign digit.
- Segmentos, out, 7: shared segment bus, polarity per SEG_ACTIVE_LOW.
- Anodos, out, 4: digit enables, polarity per AN_ACTIVE_LOW; bit k selects digit k.
- FinBarrido, out, 1: one-cycle pulse at the end of every complete 4-digit frame.

Behaviour:
- State: cnt (counts 0..PRESCALER-1); dig (2-bit, 0..3); snapshot registers sX, sY, sR (7 bits each) and sN (1 bit).
- Counter: cnt increments every enabled cycle. At cnt == PRESCALER-1, cnt goes to 0 and dig advances to dig+1, wrapping from 3 to 0.
- Digit map:
  - dig 0 shows sR.
  - dig 1 shows the sign: 7'b1000000 (segment g only) if sN = 1, else 7'h00 (blank).
  - dig 2 shows sY.
  - dig 3 shows sX.
- Slot phases, per slot:
  - BLANK phase while cnt < BLANK_CYCLES: all anodes inactive, segments inactive.
  - SHOW phase otherwise: only Anodos[dig] active; Segmentos carries that digit's code.
  - For a blank sign digit the anode is still active; all segments are off.
- Snapshot: sX, sY, sR, sN load from the inputs on every enabled cycle where cnt == 0 and dig == 0. Input changes at any other time are invisible until the next frame.
- Latency: Segmentos, Anodos and FinBarrido are registered. Their value in cycle t is the decode of (cnt, dig, snapshot) in cycle t-1.
- FinBarrido: asserted for exactly one cycle, following the cycle with dig == 3 and cnt == PRESCALER-1.
- Output polarity: pins are inverted when the matching *_ACTIVE_LOW = 1. "Inactive" means the deasserted pin level (1 when active-low).
- Enable = 0:
  - next edge: cnt to 0, dig to 0; Anodos and Segmentos inactive; FinBarrido 0.
  - snapshot registers are held.
  - On return to 1, the scan restarts at dig 0 with a BLANK phase, and the snapshot reloads on that first cycle.
- Reset (rst_n = 0), applied immediately and without a clock edge, including mid-slot:
  - cnt = 0, dig = 0, snapshot = 0.
  - Anodos and Segmentos inactive; FinBarrido = 0.
  - After release, the first enabled cycle is cnt 0 / dig 0 (snapshot load).
- BLANK_CYCLES = 0: no dark phase; the anode switches directly between digits.
- Simultaneous Enable fall and frame end: Enable wins; no FinBarrido pulse is issued.

Test Plan (PRESCALER = 8, BLANK_CYCLES = 2, both polarities active-low):
1. Reset: rst_n = 0 for 5 cycles, Enable = 1 -> Anodos = 4'b1111, Segmentos = 7'h7F, FinBarrido = 0 throughout. Drop rst_n mid-slot -> outputs go inactive before the next edge.
2. Scan: inputs R = 7'h06, N = 1, Y = 7'h5B, X = 7'h4F -> each 8-cycle slot is 2 cycles of Anodos = 1111 then 6 cycles of:
   - digit 0: Anodos = 1110, Segmentos = 7'h79
   - digit 1: Anodos = 1101, Segmentos = 7'h3F
   - digit 2: Anodos = 1011, Segmentos = 7'h24
   - digit 3: Anodos = 0111, Segmentos = 7'h30
   - FinBarrido pulses once every 32 cycles.
3. Sign blank: N = 0 -> the digit-1 slot shows Anodos = 1101, Segmentos = 7'h7F; the other digits are unchanged.
4. No tearing: change X to 7'h66 during the digit-2 slot -> digit 3 still shows 7'h30 in that frame and 7'h19 in the next.
5. Enable: drop Enable during the digit-1 SHOW phase -> one cycle later Anodos = 1111, and no FinBarrido occurs. Raise Enable -> 2 blank cycles, then digit 0 with freshly snapshotted values.
6. Parameter edge: BLANK_CYCLES = 0, PRESCALER = 2 -> Anodos steps 1110, 1101, 1011, 0111 every 2 cycles with no 1111 gaps; FinBarrido fires every 8 cycles.
